aes_cipher_iter: RTL
====================

Name: aes_cipher_iter

Overview:
- Iterative AES encryption core; the encrypt-side counterpart of the iterative decipher datapath.
- Computes one round per clock on a single 128-bit state register, reusing one round datapath: SubBytes, ShiftRows, MixColumns, AddRoundKey.
- Sits between the key-expansion block, which supplies the full round-key schedule, and the block-mode/stream logic, which exchanges blocks over valid/ready handshakes.

Parameters:
- NR, 10, number of rounds (10/12/14 for AES-128/192/256).
- NK, 4, key length in 32-bit words (4/6/8); informational only, must match NR.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  plaintext block offered.
- in_ready  output  1  core can accept a block.
- in_block  input  128  plaintext; byte 0 = [127:120], column-major per FIPS-197.
- ExpandedKeys  input  128*(NR+1)  round-key schedule; round key r = ExpandedKeys[(NR+1)*128-1-r*128 -: 128] (key 0 in MSBs, key NR in LSBs).
- out_valid  output  1  ciphertext available.
- out_ready  input  1  consumer accepts ciphertext.
- out_block  output  128  ciphertext, same byte order as in_block.

Behaviour:
- FSM states: IDLE, RUN, HOLD. Round counter rnd is [3:0] (1..NR). The state register is 128 bits.
- Reset (rst_n=0, asynchronous):
  - FSM=IDLE, rnd=0, state=0, out_valid=0, out_block=0.
  - in_ready=1 while in IDLE, including during reset.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: state <= in_block ^ key0, rnd <= 1, go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - rnd < NR: state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), key[rnd]), rnd++.
  - rnd == NR: state <= AddRoundKey(ShiftRows(SubBytes(state)), key[NR]) (no MixColumns), go to HOLD.
- HOLD:
  - out_valid=1, out_block=state.
  - On an edge with out_ready=1: go to IDLE, out_valid drops.
  - out_block holds its value until the next result; it is not cleared.
- Latency: acceptance edge E0. out_valid is high in the cycle following edge E(NR): 10 cycles for AES-128, 14 for AES-256.
- Throughput: one block per NR+2 cycles with out_ready held high.
  - The output handshake edge returns the core to IDLE.
  - in_ready rises the cycle after the handshake; there is no same-cycle re-accept.
- Backpressure: out_ready=0 in HOLD stalls the core indefinitely. out_block and out_valid stay stable; in_ready stays 0.
- in_valid while not in IDLE is ignored; the block is not consumed.
- ExpandedKeys is not registered. It must remain stable from E0 until the out handshake; changing it mid-run gives undefined ciphertext.
- Reset mid-operation (RUN or HOLD): immediate return to the reset values above. The partial state is discarded and no output is produced.
- S-box: combinational table, 16 instances on the state path. No key-schedule logic lives in this block.

Optional Feature:
- Macro AES_CIPHER_BLKCNT_EN.
- Defined:
  - Adds output blk_count [31:0], reset to 0.
  - Increments by 1 on each out_valid&&out_ready edge; wraps from FFFFFFFF to 0.
  - Reset mid-operation clears it.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- NR=10, key 000102030405060708090a0b0c0d0e0f expanded by the bench, in_block 00112233445566778899aabbccddeeff, out_ready=1 -> out_block 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid high exactly 10 cycles after acceptance, for 1 cycle.
- NR=10, key 2b7e151628aed2a6abf7158809cf4f3c, in_block 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32; intermediate state after round 1 = a49c7ff2689f352b6b5bea43026a5049.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> out_block/out_valid stable, in_ready=0, and a second in_valid is ignored. Raising out_ready -> one handshake, then in_ready=1 the next cycle.
- Reset mid-run: drop rst_n at round 5 -> out_valid=0, out_block=0, in_ready=1 immediately. The next block encrypts correctly; with AES_CIPHER_BLKCNT_EN, blk_count=0 after reset and 1 after that block.
- NR=14, NK=8, key 000102...1e1f, in_block 00112233445566778899aabbccddeeff -> 8ea2b7ca516745bfeafc49904b496089 after 14 cycles.
- Back-to-back: 3 blocks, in_valid and out_ready held high -> acceptances spaced 12 cycles apart (NR=10), ciphertexts in order.

Source files
------------

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryption core: one round per clock on a single 128-bit state register.
// Optional 32-bit completed-block counter output when AES_CIPHER_BLKCNT_EN is defined.
module aes_cipher_iter #(
  parameter int NR = 10,
  parameter int NK = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [127:0]          in_block,
  input  logic [128*(NR+1)-1:0] ExpandedKeys,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [127:0]          out_block
`ifdef AES_CIPHER_BLKCNT_EN
  ,
  output logic [31:0]           blk_count
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [3:0] LAST_RND = 4'(NR);

  if (NR != NK + 6) begin : g_nk_check
    $error("aes_cipher_iter: NK does not match NR");
  end

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Byte n of a block lives at [127-8n -: 8]; column c holds bytes 4c..4c+3 (row r = byte 4c+r).
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = SBOX[s[127-8*(4*((c+r)%4)+r) -: 8]];
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return o;
  endfunction

  logic [1:0]   fsm;
  logic [3:0]   rnd;
  logic [127:0] state;
  logic [127:0] round_key [NR+1];
  logic [127:0] sr_out;
  logic [127:0] round_out;

  for (genvar r = 0; r <= NR; r++) begin : g_round_key
    assign round_key[r] = ExpandedKeys[(NR+1)*128-1-r*128 -: 128];
  end

  always_comb begin
    sr_out    = sub_shift(state);
    round_out = (rnd == LAST_RND) ? (sr_out ^ round_key[rnd])
                                  : (mix_columns(sr_out) ^ round_key[rnd]);
  end

  assign in_ready  = (fsm == IDLE);
  assign out_valid = (fsm == HOLD);

  // out_block is a separate register so the result survives the next block's rounds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      rnd       <= '0;
      state     <= '0;
      out_block <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            state <= in_block ^ round_key[0];
            rnd   <= 4'd1;
            fsm   <= RUN;
          end
        end
        RUN: begin
          state <= round_out;
          if (rnd == LAST_RND) begin
            out_block <= round_out;
            fsm       <= HOLD;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        HOLD: begin
          if (out_ready) fsm <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

`ifdef AES_CIPHER_BLKCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_count <= '0;
    end else if (out_valid && out_ready) begin
      blk_count <= blk_count + 32'd1;
    end
  end
`endif

endmodule
